// File: rtl/tdc_ifc_pkg.sv
// Shared types and field positions for the TDC front-end control CSRs.
// One 16-bit register per channel; unimplemented bits are masked on write.
package tdc_ifc_pkg;

    typedef enum logic { IPIN = 1'b0, TOGGLE = 1'b1 } ctrl_pulse_src_t;
    typedef enum logic { TOG_FWD = 1'b0, TOG_REG = 1'b1 } ctrl_tog_t;

    typedef enum logic [3:0] {
        DL_ADD = 4'd0,
        DL_BUF = 4'd1,
        DL_MUX = 4'd2,
        DL_AND = 4'd3
    } ctrl_delay_line_t;

    typedef struct packed {
        logic [7:0]       period;
        logic             enable;
        logic             rsvd;
        ctrl_delay_line_t dl_sel;
        ctrl_tog_t        tog_mode;
        ctrl_pulse_src_t  pls_src;
    } ctrl_csr_t;

    localparam int CSR_SRC_BIT    = 0;
    localparam int CSR_TOG_BIT    = 1;
    localparam int CSR_DL_LSB     = 2;
    localparam int CSR_EN_BIT     = 7;
    localparam int CSR_PERIOD_LSB = 8;

    // Bits that actually hold state for the configured field widths.
    function automatic logic [15:0] csr_wmask(input int dl_w, input int per_w);
        logic [15:0] m;
        m = '0;
        m[CSR_SRC_BIT] = 1'b1;
        m[CSR_TOG_BIT] = 1'b1;
        m[CSR_EN_BIT]  = 1'b1;
        for (int b = 0; b < dl_w; b++)  m[CSR_DL_LSB + b]     = 1'b1;
        for (int b = 0; b < per_w; b++) m[CSR_PERIOD_LSB + b] = 1'b1;
        return m;
    endfunction

    function automatic string ctrl_csr_str(input ctrl_csr_t c);
        return $sformatf("src=%0d tog=%0d dl=%0d en=%0d period=%0d",
                         c.pls_src, c.tog_mode, c.dl_sel, c.enable, c.period);
    endfunction

endpackage

// File: rtl/tdc_tog_gen.sv
// Per-channel launch generator: registered ipin, or a period+1 toggle with optional extra stage.
// Launch is registered (1 cycle for IPIN / TOG_FWD, 2 for TOG_REG); restart clears counter and flops.
module tdc_tog_gen
    import tdc_ifc_pkg::*;
#(
    parameter int PERIOD_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_enable,
    input  ctrl_pulse_src_t     i_pls_src,
    input  ctrl_tog_t           i_tog_mode,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic                i_restart,
    input  logic                i_ipin,
    output logic                o_launch
);

    logic [PERIOD_W-1:0] r_cnt;
    logic                r_tog;
    logic                r_tog_reg;
    logic                r_ipin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_tog     <= 1'b0;
            r_tog_reg <= 1'b0;
            r_ipin    <= 1'b0;
        end else begin
            r_ipin <= i_enable & i_ipin;
            if (i_restart || !i_enable || i_pls_src != TOGGLE) begin
                r_cnt     <= '0;
                r_tog     <= 1'b0;
                r_tog_reg <= 1'b0;
            end else begin
                r_tog_reg <= r_tog;
                if (r_cnt == i_period) begin
                    r_cnt <= '0;
                    r_tog <= ~r_tog;
                end else begin
                    r_cnt <= r_cnt + PERIOD_W'(1);
                end
            end
        end
    end

    logic w_tog_out;
    assign w_tog_out = (i_tog_mode == TOG_REG) ? r_tog_reg : r_tog;
    assign o_launch  = i_enable & ((i_pls_src == TOGGLE) ? w_tog_out : r_ipin);

endmodule

// File: rtl/tdc_ctrl_csr_bank.sv
// Multi-channel TDC control CSR bank plus per-channel launch generation.
// Reads return 1 cycle after request; each accepted write costs one not-ready cycle.
module tdc_ctrl_csr_bank
    import tdc_ifc_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DL_SEL_W = 2,
    parameter int PERIOD_W = 8,
    // Normally derived; may be widened so addresses beyond NUM_CH are expressible.
    parameter int ADDR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     csr_wr_valid,
    output logic                     csr_wr_ready,
    input  logic [ADDR_W-1:0]        csr_addr,
    input  logic [15:0]              csr_wdata,
    input  logic                     csr_rd_req,
    output logic                     csr_rd_valid,
    output logic [15:0]              csr_rdata,
    output logic                     csr_err,
    input  logic [NUM_CH-1:0]        ipin,
    output logic [NUM_CH-1:0]        launch,
    output logic [NUM_CH*DL_SEL_W-1:0] ch_dl_sel
);

    localparam logic [15:0] WMASK = csr_wmask(DL_SEL_W, PERIOD_W);

    ctrl_csr_t   r_csr [NUM_CH];
    logic        r_wr_ready;
    logic        r_rd_valid;
    logic [15:0] r_rdata;
    logic        r_err;

    logic        w_wr_acc;
    logic        w_addr_ok;
    logic [15:0] w_rd_dat;

    assign w_wr_acc  = csr_wr_valid && r_wr_ready;
    assign w_addr_ok = int'(csr_addr) < NUM_CH;

    always_comb begin
        w_rd_dat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (csr_addr == ADDR_W'(c)) w_rd_dat = r_csr[c];
        end
    end

    // Nonblocking update means a same-edge read sees the pre-write value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) r_csr[c] <= '0;
            r_wr_ready <= 1'b1;
            r_rd_valid <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_wr_acc && csr_addr == ADDR_W'(c)) r_csr[c] <= ctrl_csr_t'(csr_wdata & WMASK);
            end
            r_wr_ready <= !w_wr_acc;
            r_rd_valid <= csr_rd_req;
            if (csr_rd_req) r_rdata <= w_addr_ok ? w_rd_dat : 16'h0000;
            r_err <= !w_addr_ok && (w_wr_acc || csr_rd_req);
        end
    end

    assign csr_wr_ready = r_wr_ready;
    assign csr_rd_valid = r_rd_valid;
    assign csr_rdata    = r_rdata;
    assign csr_err      = r_err;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ctrl_csr_t w_c;
        logic      w_restart;

        assign w_c       = r_csr[i];
        assign w_restart = w_wr_acc && (csr_addr == ADDR_W'(i));
        assign ch_dl_sel[i*DL_SEL_W +: DL_SEL_W] = w_c.dl_sel[DL_SEL_W-1:0];

        tdc_tog_gen #(.PERIOD_W(PERIOD_W)) u_tog_gen (
            .clk        (clk),
            .rst        (rst),
            .i_enable   (w_c.enable),
            .i_pls_src  (w_c.pls_src),
            .i_tog_mode (w_c.tog_mode),
            .i_period   (w_c.period[PERIOD_W-1:0]),
            .i_restart  (w_restart),
            .i_ipin     (ipin[i]),
            .o_launch   (launch[i])
        );
    end

endmodule

// File: tb/tb_tdc_ctrl_csr_bank.sv
// Directed bench for tdc_ctrl_csr_bank with NUM_CH=4 and a 3-bit address so addr 5 is reachable.
module tb_tdc_ctrl_csr_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_wr_valid;
    logic        csr_wr_ready;
    logic [2:0]  csr_addr;
    logic [15:0] csr_wdata;
    logic        csr_rd_req;
    logic        csr_rd_valid;
    logic [15:0] csr_rdata;
    logic        csr_err;
    logic [3:0]  ipin;
    logic [3:0]  launch;
    logic [7:0]  ch_dl_sel;

    int n_checks = 0;
    int n_errors = 0;

    tdc_ctrl_csr_bank #(.NUM_CH(4), .DL_SEL_W(2), .PERIOD_W(8), .ADDR_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .csr_wr_valid (csr_wr_valid),
        .csr_wr_ready (csr_wr_ready),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rd_req   (csr_rd_req),
        .csr_rd_valid (csr_rd_valid),
        .csr_rdata    (csr_rdata),
        .csr_err      (csr_err),
        .ipin         (ipin),
        .launch       (launch),
        .ch_dl_sel    (ch_dl_sel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_start(input logic [2:0] a, input logic [15:0] d);
        csr_wr_valid = 1'b1;
        csr_addr     = a;
        csr_wdata    = d;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        wr_start(a, d);
        tick();
        csr_wr_valid = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [2:0] a, output logic [15:0] d, output logic v);
        csr_addr   = a;
        csr_rd_req = 1'b1;
        tick();
        csr_rd_req = 1'b0;
        d = csr_rdata;
        v = csr_rd_valid;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic        v;
        n_checks++;
        if (launch !== 4'b0000) begin n_errors++; $display("FAIL reset_launch got %b want 0000", launch); end
        n_checks++;
        if (csr_wr_ready !== 1'b1) begin n_errors++; $display("FAIL reset_wr_ready got %b want 1", csr_wr_ready); end
        n_checks++;
        if (csr_rd_valid !== 1'b0 || csr_err !== 1'b0 || csr_rdata !== 16'h0000)
            begin n_errors++; $display("FAIL reset_rd got v=%b e=%b d=%h want 0 0 0000", csr_rd_valid, csr_err, csr_rdata); end
        n_checks++;
        if (ch_dl_sel !== 8'h00) begin n_errors++; $display("FAIL reset_dl_sel got %h want 00", ch_dl_sel); end
        rst = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) begin
            do_read(3'(c), d, v);
            n_checks++;
            if (d !== 16'h0000 || v !== 1'b1)
                begin n_errors++; $display("FAIL reset_read ch%0d got %h v=%b want 0000 v=1", c, d, v); end
        end
    endtask

    task automatic test_toggle_fwd();
        logic [3:0] e;
        wr_start(3'd2, 16'h0381);
        n_checks++;
        if (csr_wr_ready !== 1'b1) begin n_errors++; $display("FAIL fwd_ready_pre got %b want 1", csr_wr_ready); end
        tick();
        n_checks++;
        if (csr_wr_ready !== 1'b0 || launch !== 4'b0000)
            begin n_errors++; $display("FAIL fwd_apply got rdy=%b launch=%b want 0 0000", csr_wr_ready, launch); end
        // valid still held through the busy cycle: must not be accepted again
        tick();
        csr_wr_valid = 1'b0;
        n_checks++;
        if (csr_wr_ready !== 1'b1) begin n_errors++; $display("FAIL fwd_ready_back got %b want 1", csr_wr_ready); end
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) tick();
            e = 4'b0000;
            e[2] = ((k / 4) % 2) == 1;
            n_checks++;
            if (launch !== e) begin n_errors++; $display("FAIL fwd_wave k=%0d got %b want %b", k, launch, e); end
        end
    endtask

    task automatic test_tog_reg();
        logic [3:0] e;
        wr_start(3'd2, 16'h0383);
        tick();
        csr_wr_valid = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) tick();
            e = 4'b0000;
            e[2] = (k > 0) && ((((k - 1) / 4) % 2) == 1);
            n_checks++;
            if (launch !== e) begin n_errors++; $display("FAIL reg_wave k=%0d got %b want %b", k, launch, e); end
        end
        wr_start(3'd2, 16'h0081);
        tick();
        csr_wr_valid = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) tick();
            e = 4'b0000;
            e[2] = (k % 2) == 1;
            n_checks++;
            if (launch !== e) begin n_errors++; $display("FAIL fwd_p0 k=%0d got %b want %b", k, launch, e); end
        end
        wr_start(3'd2, 16'h0083);
        tick();
        csr_wr_valid = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) tick();
            e = 4'b0000;
            e[2] = (k > 0) && (((k - 1) % 2) == 1);
            n_checks++;
            if (launch !== e) begin n_errors++; $display("FAIL reg_p0 k=%0d got %b want %b", k, launch, e); end
        end
    endtask

    task automatic test_ipin();
        logic [3:0] pat;
        pat = 4'b1011;
        do_write(3'd2, 16'h0000);
        do_write(3'd0, 16'h0080);
        for (int j = 0; j < 4; j++) begin
            ipin[0] = pat[3-j];
            tick();
            n_checks++;
            if (launch !== {3'b000, pat[3-j]})
                begin n_errors++; $display("FAIL ipin_pat j=%0d got %b want %b", j, launch, {3'b000, pat[3-j]}); end
        end
        wr_start(3'd0, 16'h0000);
        tick();
        csr_wr_valid = 1'b0;
        n_checks++;
        if (launch !== 4'b0000) begin n_errors++; $display("FAIL ipin_disable got %b want 0000", launch); end
        tick();
        n_checks++;
        if (launch !== 4'b0000) begin n_errors++; $display("FAIL ipin_disable_hold got %b want 0000", launch); end
        ipin = 4'b0000;
    endtask

    task automatic test_rd_wr_same();
        logic [15:0] d;
        logic        v;
        wr_start(3'd1, 16'h0081);
        csr_rd_req = 1'b1;
        tick();
        csr_wr_valid = 1'b0;
        csr_rd_req   = 1'b0;
        n_checks++;
        if (csr_rdata !== 16'h0000 || csr_rd_valid !== 1'b1)
            begin n_errors++; $display("FAIL same_edge_old got %h v=%b want 0000 v=1", csr_rdata, csr_rd_valid); end
        tick();
        n_checks++;
        if (csr_rd_valid !== 1'b0) begin n_errors++; $display("FAIL rd_valid_pulse got %b want 0", csr_rd_valid); end
        do_read(3'd1, d, v);
        n_checks++;
        if (d !== 16'h0081 || v !== 1'b1) begin n_errors++; $display("FAIL same_edge_new got %h v=%b want 0081 v=1", d, v); end
        tick();
        n_checks++;
        if (csr_rdata !== 16'h0081 || csr_rd_valid !== 1'b0)
            begin n_errors++; $display("FAIL rdata_hold got %h v=%b want 0081 v=0", csr_rdata, csr_rd_valid); end
    endtask

    task automatic test_out_of_range();
        logic [15:0] d;
        logic        v;
        logic [15:0] exp_ch [4];
        exp_ch[0] = 16'h0000; exp_ch[1] = 16'h0081; exp_ch[2] = 16'h0000; exp_ch[3] = 16'h0000;
        wr_start(3'd5, 16'hFFFF);
        tick();
        n_checks++;
        if (csr_wr_ready !== 1'b0 || csr_err !== 1'b1)
            begin n_errors++; $display("FAIL oor_wr got rdy=%b err=%b want 0 1", csr_wr_ready, csr_err); end
        csr_wr_valid = 1'b0;
        tick();
        n_checks++;
        if (csr_wr_ready !== 1'b1 || csr_err !== 1'b0)
            begin n_errors++; $display("FAIL oor_wr_after got rdy=%b err=%b want 1 0", csr_wr_ready, csr_err); end
        do_read(3'd5, d, v);
        n_checks++;
        if (d !== 16'h0000 || v !== 1'b1 || csr_err !== 1'b1)
            begin n_errors++; $display("FAIL oor_rd got %h v=%b err=%b want 0000 1 1", d, v, csr_err); end
        tick();
        n_checks++;
        if (csr_err !== 1'b0) begin n_errors++; $display("FAIL oor_err_pulse got %b want 0", csr_err); end
        for (int c = 0; c < 4; c++) begin
            do_read(3'(c), d, v);
            n_checks++;
            if (d !== exp_ch[c] || csr_err !== 1'b0)
                begin n_errors++; $display("FAIL oor_nochange ch%0d got %h err=%b want %h 0", c, d, csr_err, exp_ch[c]); end
        end
    endtask

    task automatic test_mask_dlsel();
        logic [15:0] d;
        logic        v;
        do_write(3'd3, 16'hFFFF);
        do_read(3'd3, d, v);
        n_checks++;
        if (d !== 16'hFF8F) begin n_errors++; $display("FAIL wmask got %h want ff8f", d); end
        n_checks++;
        if (ch_dl_sel !== 8'hC0) begin n_errors++; $display("FAIL dl_sel got %h want c0", ch_dl_sel); end
        do_write(3'd3, 16'h0000);
        n_checks++;
        if (ch_dl_sel !== 8'h00) begin n_errors++; $display("FAIL dl_sel_clr got %h want 00", ch_dl_sel); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        logic        v;
        logic [3:0]  e;
        wr_start(3'd2, 16'h0181);
        tick();
        csr_wr_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (launch[2] !== 1'b1) begin n_errors++; $display("FAIL mid_pre got %b want 1", launch[2]); end
        csr_addr   = 3'd2;
        csr_rd_req = 1'b1;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (launch !== 4'b0000 || csr_wr_ready !== 1'b1)
            begin n_errors++; $display("FAIL mid_async got launch=%b rdy=%b want 0000 1", launch, csr_wr_ready); end
        tick();
        n_checks++;
        if (csr_rd_valid !== 1'b0) begin n_errors++; $display("FAIL mid_rd_drop got %b want 0", csr_rd_valid); end
        rst        = 1'b0;
        csr_rd_req = 1'b0;
        do_read(3'd2, d, v);
        n_checks++;
        if (d !== 16'h0000) begin n_errors++; $display("FAIL mid_reg_clr got %h want 0000", d); end
        wr_start(3'd2, 16'h0181);
        tick();
        csr_wr_valid = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) tick();
            e = 4'b0000;
            e[2] = ((k / 2) % 2) == 1;
            n_checks++;
            if (launch !== e) begin n_errors++; $display("FAIL mid_restart k=%0d got %b want %b", k, launch, e); end
        end
    endtask

    initial begin
        rst          = 1'b1;
        csr_wr_valid = 1'b0;
        csr_addr     = '0;
        csr_wdata    = '0;
        csr_rd_req   = 1'b0;
        ipin         = '0;
        tick();
        tick();
        test_reset();
        test_toggle_fwd();
        test_tog_reg();
        test_ipin();
        test_rd_wr_same();
        test_out_of_range();
        test_mask_dlsel();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
